inst_fetch_unit: RTL and testbench

- Instruction fetch stage for the single-issue MIPS datapath.
- Holds the byte-address PC and computes the sequential, branch, jump, jr and flush targets.
- Branch targets re-scale the unshifted sign-extended word offset into a byte offset.
- Issues word-indexed requests to the instruction memory and presents one fetched instruction at a time to decode, with stall/flush handshakes.

---
 rtl/inst_fetch_unit_if.sv | 33 +++
 rtl/inst_fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Purpose  : Instruction-memory request/grant/read-data bus used by the fetch
//            unit (master) and the instruction memory (slave).
// Revision : 1.0
// ============================================================================
interface inst_fetch_unit_if #(
  parameter int unsigned IMEM_AW = 10
) ();
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [31:0]        imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : MIPS fetch stage: byte-address PC, redirect targets, one
//            outstanding imem request, single-entry hand-off to decode.
//            Optional FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap.
// Revision : 1.0
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          stall,
  input  wire logic          branch_taken,
  input  wire logic [31:0]   branch_imm,
  input  wire logic          jump,
  input  wire logic [25:0]   jump_target,
  input  wire logic          jr,
  input  wire logic [31:0]   jr_addr,
  input  wire logic          flush,
  input  wire logic [31:0]   flush_addr,
  inst_fetch_unit_if.master  imem,
  output logic               inst_valid,
  output logic [31:0]        inst_out,
  output logic [31:0]        pc_out,
  output logic               misalign
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        inst_valid_q, inst_valid_d;
  logic        kill_q, kill_d;
  logic        imem_req_q, imem_req_d;
  logic        take_trap;

  logic [31:0] w_p4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_flush_tgt;
  logic        w_jr_bad;
  logic        w_flush_bad;

  // Redirects are computed relative to the instruction being handed to decode.
  assign w_p4        = pc_out_q + 32'd4;
  assign w_br_tgt    = w_p4 + {branch_imm[29:0], 2'b00};
  assign w_jump_tgt  = {w_p4[31:28], jump_target, 2'b00};
  assign w_jr_tgt    = {jr_addr[31:2], 2'b00};
  assign w_flush_tgt = {flush_addr[31:2], 2'b00};

  logic unused_imm_msbs;
  assign unused_imm_msbs = ^branch_imm[31:30];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign w_jr_bad    = |jr_addr[1:0];
  assign w_flush_bad = |flush_addr[1:0];
  assign misalign_d  = misalign_q | take_trap;
  assign misalign    = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_addr_lsbs;

  assign w_jr_bad         = 1'b0;
  assign w_flush_bad      = 1'b0;
  assign misalign         = 1'b0;
  assign unused_addr_lsbs = ^{jr_addr[1:0], flush_addr[1:0]};
`endif

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    inst_out_d   = inst_out_q;
    pc_out_d     = pc_out_q;
    inst_valid_d = inst_valid_q;
    kill_d       = kill_q;
    take_trap    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_out_d   = imem.imem_rdata;
            pc_out_d     = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
          if (jr) begin
            if (w_jr_bad) take_trap = 1'b1;
            else          fetch_pc_d = w_jr_tgt;
          end else if (jump) begin
            fetch_pc_d = w_jump_tgt;
          end else if (branch_taken) begin
            fetch_pc_d = w_br_tgt;
          end
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // A flush overrides everything above; an in-flight read is tagged so its
    // data is dropped when it returns (unless it returns in this very cycle).
    if (flush && state_q != S_TRAP) begin
      inst_valid_d = 1'b0;
      inst_out_d   = inst_out_q;
      pc_out_d     = pc_out_q;
      take_trap    = w_flush_bad;
      if (!w_flush_bad) fetch_pc_d = w_flush_tgt;
      if ((state_q == S_WAIT && !imem.imem_rvalid) ||
          (state_q == S_REQ && imem.imem_gnt)) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = S_REQ;
      end
    end

    if (take_trap) begin
      state_d      = S_TRAP;
      inst_valid_d = 1'b0;
      kill_d       = 1'b0;
    end

    imem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      inst_out_q   <= 32'h0;
      pc_out_q     <= 32'h0;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign pc_out         = pc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Directed bench for inst_fetch_unit with a transaction-level model
//            and an address-tagged instruction memory responder.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_unit;
  localparam int unsigned IMEM_AW = 10;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump, jr, flush;
  logic [31:0] branch_imm, jr_addr, flush_addr;
  logic [25:0] jump_target;
  logic        inst_valid, misalign;
  logic [31:0] inst_out, pc_out;
  logic        gnt_en;
  int          lat;

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_unit_if #(.IMEM_AW(IMEM_AW)) bus ();

  inst_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_addr(jr_addr), .flush(flush), .flush_addr(flush_addr),
    .imem(bus), .inst_valid(inst_valid), .inst_out(inst_out),
    .pc_out(pc_out), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [9:0] w);
    return {8'hA5, 14'h0, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  logic        fire_s = 1'b0;
  logic [9:0]  addr_s = '0;
  int          rv_cnt = 0;
  logic [31:0] rv_data = '0;

  assign bus.imem_gnt    = bus.imem_req & gnt_en;
  assign bus.imem_rvalid = (rv_cnt == 1);
  assign bus.imem_rdata  = bus.imem_rvalid ? rv_data : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    fire_s = bus.imem_req & bus.imem_gnt;
    addr_s = bus.imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (fire_s) begin
      rv_cnt  = lat;
      rv_data = tag(addr_s);
    end else if (rv_cnt != 0) begin
      rv_cnt--;
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct { logic [31:0] pc; bit killed; } pend_t;
  pend_t       q[$];
  logic [31:0] m_fetch_pc, m_pc, m_inst;
  bit          m_valid, m_idle, m_trap, m_live = 1'b0;

  always @(negedge clk) begin : model
    bit          was_valid, exp_req;
    logic [31:0] p4;
    pend_t       e;
    if (rst) begin
      m_live = 1'b1; m_fetch_pc = 32'h0; m_valid = 1'b0;
      m_idle = 1'b1; m_trap = 1'b0; q.delete();
    end else if (m_live) begin
      exp_req = !m_idle && !m_valid && (q.size() == 0) && !m_trap;
      chk("imem_req", bus.imem_req, exp_req);
      if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch_pc[11:2]);
      chk("inst_valid", inst_valid, m_valid);
      if (m_valid) begin
        chk("pc_out", pc_out, m_pc);
        chk("inst_out", inst_out, m_inst);
      end
      chk("misalign", misalign, m_trap);
      if (!m_trap) begin
        was_valid = m_valid;
        m_idle = 1'b0;
        if (bus.imem_rvalid && q.size() > 0) begin
          e = q.pop_front();
          if (!e.killed) begin
            m_valid = 1'b1; m_pc = e.pc; m_inst = tag(e.pc[11:2]);
          end
        end
        if (bus.imem_req && bus.imem_gnt) begin
          q.push_back('{m_fetch_pc, 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (was_valid && !stall) begin
          m_valid = 1'b0;
          p4 = m_pc + 32'd4;
          if (jr) begin
            if (TRAP_EN && jr_addr[1:0] != 2'b00) m_trap = 1'b1;
            else m_fetch_pc = jr_addr & 32'hFFFF_FFFC;
          end else if (jump) begin
            m_fetch_pc = (p4 & 32'hF000_0000) | (32'(jump_target) * 4);
          end else if (branch_taken) begin
            m_fetch_pc = p4 + branch_imm * 4;
          end
        end
        if (flush) begin
          m_valid = 1'b0;
          foreach (q[i]) q[i].killed = 1'b1;
          if (TRAP_EN && flush_addr[1:0] != 2'b00) m_trap = 1'b1;
          else m_fetch_pc = flush_addr & 32'hFFFF_FFFC;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: got timeout, expected inst_valid within 50 cycles");
    end
  endtask

  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: got timeout, expected imem_req within 50 cycles");
    end
  endtask

  task automatic consume(input logic i_jr, input logic [31:0] i_jra,
                         input logic i_j, input logic [25:0] i_jt,
                         input logic i_br, input logic [31:0] i_imm);
    @(posedge clk); #1;
    jr = i_jr; jr_addr = i_jra; jump = i_j; jump_target = i_jt;
    branch_taken = i_br; branch_imm = i_imm; stall = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1; jr = 0; jump = 0; branch_taken = 0;
  endtask

  initial begin : stim
    int          nreq, nv;
    logic [9:0]  addrs[16];
    logic [31:0] pcs[16];
    int          vcyc[16];
    rst = 1; stall = 0; branch_taken = 0; jump = 0; jr = 0; flush = 0;
    branch_imm = 0; jr_addr = 0; flush_addr = 0; jump_target = 0;
    gnt_en = 1; lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst imem_req", bus.imem_req, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_out", inst_out, 0);
    chk("rst pc_out", pc_out, 0);
    chk("rst misalign", misalign, 0);
    @(posedge clk); #1 rst = 0;

    // free-running sequential fetch
    nreq = 0; nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req) begin addrs[nreq] = bus.imem_addr; nreq++; end
      if (inst_valid) begin pcs[nv] = pc_out; vcyc[nv] = c; nv++; end
    end
    chk("seq nreq", nreq, 3);
    chk("seq nvalid", nv, 3);
    if (nreq >= 3 && nv >= 3) begin
      chk("seq addr0", addrs[0], 0);
      chk("seq addr1", addrs[1], 1);
      chk("seq addr2", addrs[2], 2);
      chk("seq pc0", pcs[0], 32'h0);
      chk("seq pc1", pcs[1], 32'h4);
      chk("seq pc2", pcs[2], 32'h8);
      chk("first latency", vcyc[0], 3);
      chk("period a", vcyc[1] - vcyc[0], 3);
      chk("period b", vcyc[2] - vcyc[1], 3);
    end
    @(posedge clk); #1 stall = 1;
    wait_valid();
    chk("held pc", pc_out, 32'hC);

    // branch with negative offset
    consume(1, 32'h100, 0, 0, 0, 0);
    wait_valid();
    chk("jr pc", pc_out, 32'h100);
    chk("jr inst", inst_out, 32'hA500_0040);
    consume(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    wait_req();
    chk("branch addr", bus.imem_addr, 10'h3F);
    wait_valid();
    chk("branch pc", pc_out, 32'h0000_00FC);

    // jump and jr-over-jump priority
    consume(1, 32'h1000_0040, 0, 0, 0, 0);
    wait_valid();
    consume(0, 0, 1, 26'h000_0010, 0, 0);
    wait_valid();
    chk("jump pc", pc_out, 32'h1000_0040);
    consume(1, 32'h200, 1, 26'h000_0010, 0, 0);
    wait_valid();
    chk("jr wins pc", pc_out, 32'h200);

    // stall holds the instruction, redirects ignored
    @(posedge clk); #1 branch_taken = 1; branch_imm = 32'h40; gnt_en = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall pc", pc_out, 32'h200);
      chk("stall inst", inst_out, 32'hA500_0080);
      chk("stall req", bus.imem_req, 0);
      chk("stall valid", inst_valid, 1);
    end
    consume(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("nognt req", bus.imem_req, 1);
      chk("nognt addr", bus.imem_addr, 10'h81);
    end
    @(posedge clk); #1 gnt_en = 1;
    wait_valid();
    chk("seq after stall", pc_out, 32'h204);

    // flush in WAIT discards the returning data
    lat = 2;
    consume(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 flush = 1; flush_addr = 32'h80;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("killed data valid", inst_valid, 0);
    wait_req();
    chk("flush addr", bus.imem_addr, 10'h20);
    wait_valid();
    chk("flush pc", pc_out, 32'h80);
    chk("flush inst", inst_out, 32'hA500_0020);

    // reset in WAIT
    consume(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("wait rst req", bus.imem_req, 0);
    chk("wait rst valid", inst_valid, 0);
    chk("wait rst inst", inst_out, 0);
    chk("wait rst pc", pc_out, 0);
    chk("wait rst misalign", misalign, 0);
    lat = 1;
    wait_valid();
    chk("post rst pc", pc_out, 32'h0);

    // misaligned jr target
    consume(1, 32'h203, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("trap misalign", misalign, 1);
      chk("trap req", bus.imem_req, 0);
      chk("trap valid", inst_valid, 0);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    wait_valid();
    chk("trap exit pc", pc_out, 32'h0);
    chk("trap exit misalign", misalign, 0);
`else
    wait_req();
    chk("misaligned jr addr", bus.imem_addr, 10'h80);
    chk("no misalign", misalign, 0);
    wait_valid();
    chk("misaligned jr pc", pc_out, 32'h200);
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
